// File: rtl/vga_sync_decoder_if.sv
// Sync bundle from a VGA timing source (master) to a sync decoder (slave).
// Both syncs are active-low pulses in the decoder's clock domain.
interface vga_sync_decoder_if;
  logic h_sync;
  logic v_sync;

  modport master (output h_sync, output v_sync);
  modport slave  (input  h_sync, input  v_sync);
endinterface

// File: rtl/vga_sync_decoder.sv
// Rebuilds x/y from incoming h/v sync, locks after LOCK_FRAMES clean frames, and emits draw_active/x/y one cycle late.
// Define VGA_SYNC_WIDTH_CHECK_EN to also require sync pulse widths to match in VERIFY and LOCKED.
module vga_sync_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  vga_sync_decoder_if.slave           sync_if,
  output logic                        o_locked,
  output logic                        o_lock_lost,
  output logic                        o_frame_start,
  output logic                        o_draw_active,
  output logic [$clog2(H_ACTIVE)-1:0] o_active_x,
  output logic [$clog2(V_ACTIVE)-1:0] o_active_y,
  output logic [7:0]                  o_err_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int VS_START = V_ACTIVE + V_FRONT;

  localparam int X_W  = $clog2(H_TOTAL);
  localparam int Y_W  = $clog2(V_TOTAL);
  localparam int XA_W = $clog2(H_ACTIVE);
  localparam int YA_W = $clog2(V_ACTIVE);
  localparam int FC_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [X_W-1:0]  X_LAST      = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]  X_HS_START  = X_W'(HS_START);
  localparam logic [X_W-1:0]  X_HUNT_LOAD = X_W'((HS_START + 1) % H_TOTAL);
  localparam logic [X_W-1:0]  X_ACTIVE    = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]  Y_LAST      = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]  Y_VS_START  = Y_W'(VS_START);
  localparam logic [Y_W-1:0]  Y_ACTIVE    = Y_W'(V_ACTIVE);
  localparam logic [FC_W-1:0] FC_LOCK     = FC_W'(LOCK_FRAMES);
`ifdef VGA_SYNC_WIDTH_CHECK_EN
  localparam logic [X_W-1:0]  X_HS_END    = X_W'(HS_START + H_SYNC);
  localparam logic [Y_W-1:0]  Y_VS_END    = Y_W'(VS_START + V_SYNC);
`endif

  typedef enum logic [1:0] {
    S_HUNT_H,
    S_HUNT_V,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t          r_state;
  logic [X_W-1:0]  r_x_cnt;
  logic [Y_W-1:0]  r_y_cnt;
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_h_prev;
  logic            r_v_prev;

  logic            r_lock_lost;
  logic            r_frame_start;
  logic            r_draw_active;
  logic [XA_W-1:0] r_active_x;
  logic [YA_W-1:0] r_active_y;
  logic [7:0]      r_err_cnt;

  state_t          w_state_nxt;
  logic [X_W-1:0]  w_x_nxt;
  logic [Y_W-1:0]  w_y_nxt;
  logic [FC_W-1:0] w_frame_nxt;

  logic            w_lock_lost_nxt;
  logic            w_frame_start_nxt;
  logic            w_draw_nxt;
  logic [XA_W-1:0] w_active_x_nxt;
  logic [YA_W-1:0] w_active_y_nxt;
  logic [7:0]      w_err_cnt_nxt;

  logic            w_h_fall;
  logic            w_v_fall;
  logic            w_at_x0;
  logic            w_at_hs;
  logic            w_at_vs;
  logic            w_checking;
  logic            w_h_err;
  logic            w_v_err;
  logic            w_width_err;
  logic            w_err;
  logic            w_run_ok;
  logic            w_x_wrap;
  logic            w_frame_end;
  logic [X_W-1:0]  w_x_inc;
  logic [Y_W-1:0]  w_y_inc;
  logic [FC_W-1:0] w_frame_inc;

  // Edge detection and position predicates for the sample on the inputs this cycle.
  assign w_h_fall   = r_h_prev & ~sync_if.h_sync;
  assign w_v_fall   = r_v_prev & ~sync_if.v_sync;
  assign w_at_x0    = (r_x_cnt == '0);
  assign w_at_hs    = (r_x_cnt == X_HS_START);
  assign w_at_vs    = w_at_x0 && (r_y_cnt == Y_VS_START);
  assign w_checking = (r_state == S_VERIFY) || (r_state == S_LOCKED);

  assign w_h_err = (r_state != S_HUNT_H) && (w_h_fall != w_at_hs);
  assign w_v_err = (r_state == S_HUNT_V) ? (w_v_fall && !w_at_x0)
                                         : (w_checking && (w_v_fall != w_at_vs));

`ifdef VGA_SYNC_WIDTH_CHECK_EN
  logic w_h_rise;
  logic w_v_rise;
  assign w_h_rise    = ~r_h_prev & sync_if.h_sync;
  assign w_v_rise    = ~r_v_prev & sync_if.v_sync;
  assign w_width_err = w_checking &&
                       ((w_h_rise != (r_x_cnt == X_HS_END)) ||
                        (w_v_rise != (w_at_x0 && (r_y_cnt == Y_VS_END))));
`else
  assign w_width_err = 1'b0;
`endif

  // Simultaneous h, v and width faults collapse into a single error event.
  assign w_err = w_h_err | w_v_err | w_width_err;

  assign w_x_wrap    = (r_x_cnt == X_LAST);
  assign w_frame_end = w_x_wrap && (r_y_cnt == Y_LAST);
  assign w_x_inc     = w_x_wrap ? '0 : r_x_cnt + X_W'(1);
  assign w_y_inc     = !w_x_wrap              ? r_y_cnt :
                       (r_y_cnt == Y_LAST)    ? '0      : r_y_cnt + Y_W'(1);
  assign w_frame_inc = r_frame_cnt + FC_W'(1);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking only in clocked blocks, so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_HUNT_H;
      r_x_cnt     <= '0;
      r_y_cnt     <= '0;
      r_frame_cnt <= '0;
      r_h_prev    <= 1'b1;
      r_v_prev    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_x_cnt     <= w_x_nxt;
      r_y_cnt     <= w_y_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_h_prev    <= sync_if.h_sync;
      r_v_prev    <= sync_if.v_sync;
    end
  end

  always_comb begin
    // NOTE: default every comb output first so no branch can infer a latch.
    w_state_nxt = r_state;
    w_x_nxt     = w_x_inc;
    w_y_nxt     = w_y_inc;
    w_frame_nxt = r_frame_cnt;
    case (r_state)
      S_HUNT_H: begin
        w_x_nxt = '0;
        w_y_nxt = '0;
        if (w_h_fall) begin
          w_x_nxt     = X_HUNT_LOAD;
          w_state_nxt = S_HUNT_V;
        end
      end
      S_HUNT_V: begin
        if (w_v_fall && w_at_x0) begin
          w_y_nxt     = Y_VS_START;
          w_frame_nxt = '0;
          w_state_nxt = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (w_frame_end) begin
          w_frame_nxt = w_frame_inc;
          if (w_frame_inc == FC_LOCK) w_state_nxt = S_LOCKED;
        end
      end
      default: ;
    endcase
    // The error cycle's own h_fall is dropped: hunting restarts on the next one.
    if (w_err) begin
      w_state_nxt = S_HUNT_H;
      w_x_nxt     = '0;
      w_y_nxt     = '0;
      w_frame_nxt = '0;
    end
  end

  always_comb begin
    w_run_ok          = (r_state == S_LOCKED) && !w_err;
    w_draw_nxt        = w_run_ok && (r_x_cnt < X_ACTIVE) && (r_y_cnt < Y_ACTIVE);
    w_frame_start_nxt = w_run_ok && w_at_x0 && (r_y_cnt == '0);
    w_lock_lost_nxt   = (r_state == S_LOCKED) && w_err;
    w_active_x_nxt    = w_draw_nxt ? r_x_cnt[XA_W-1:0] : '0;
    w_active_y_nxt    = w_draw_nxt ? r_y_cnt[YA_W-1:0] : '0;
    w_err_cnt_nxt     = (w_err && (r_err_cnt != 8'hFF)) ? r_err_cnt + 8'd1 : r_err_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_lost   <= 1'b0;
      r_frame_start <= 1'b0;
      r_draw_active <= 1'b0;
      r_active_x    <= '0;
      r_active_y    <= '0;
      r_err_cnt     <= '0;
    end else begin
      r_lock_lost   <= w_lock_lost_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_draw_active <= w_draw_nxt;
      r_active_x    <= w_active_x_nxt;
      r_active_y    <= w_active_y_nxt;
      r_err_cnt     <= w_err_cnt_nxt;
    end
  end

  assign o_locked      = (r_state == S_LOCKED);
  assign o_lock_lost   = r_lock_lost;
  assign o_frame_start = r_frame_start;
  assign o_draw_active = r_draw_active;
  assign o_active_x    = r_active_x;
  assign o_active_y    = r_active_y;
  assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 8x6 raster: golden sync generator,
// pixel scoreboard while locked, and fault injection on single lines.
module tb_vga_sync_decoder;

  localparam int H_ACTIVE = 8, H_FRONT = 2, H_SYNC = 3, H_BACK = 3;
  localparam int V_ACTIVE = 6, V_FRONT = 1, V_SYNC = 2, V_BACK = 2;
  localparam int LOCK_FRAMES = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       o_locked, o_lock_lost, o_frame_start, o_draw_active;
  logic [2:0] o_active_x, o_active_y;
  logic [7:0] o_err_cnt;

  always #5 clk = ~clk;

  vga_sync_decoder_if sif ();

  vga_sync_decoder #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sync_if       (sif),
    .o_locked      (o_locked),
    .o_lock_lost   (o_lock_lost),
    .o_frame_start (o_frame_start),
    .o_draw_active (o_draw_active),
    .o_active_x    (o_active_x),
    .o_active_y    (o_active_y),
    .o_err_cnt     (o_err_cnt)
  );

  typedef struct packed {
    logic       fs;
    logic       draw;
    logic [2:0] x;
    logic [2:0] y;
  } pix_t;

  pix_t sb_q[$];
  int   n_pass = 0, n_fail = 0, n_total = 0;
  int   gx = 0, gy = 0;
  bit   sb_on = 0, mod_delay = 0, mod_stretch = 0, mod_skip = 0;
  int   lost_x = -1, lost_err = -1, lost_pulses = 0;
  int   exp_err = 0;
  int   n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock of the golden generator; expected pixels are queued at drive time and popped after the edge.
  task automatic tick(input logic r);
    int   hs_lo, hs_hi;
    pix_t e, o;
    hs_lo       = HS_START + (mod_delay ? 1 : 0);
    hs_hi       = HS_END + (mod_stretch ? 1 : 0);
    sif.h_sync  = mod_skip ? 1'b1 : !(gx >= hs_lo && gx < hs_hi);
    sif.v_sync  = !(gy >= VS_START && gy < VS_END);
    rst         = r;
    if (sb_on) begin
      e.draw = (gx < H_ACTIVE) && (gy < V_ACTIVE);
      e.x    = e.draw ? 3'(gx) : 3'd0;
      e.y    = e.draw ? 3'(gy) : 3'd0;
      e.fs   = (gx == 0) && (gy == 0);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (o_lock_lost === 1'b1) begin
      lost_pulses++;
      if (lost_x < 0) begin
        lost_x   = gx;
        lost_err = int'(o_err_cnt);
      end
    end
    if (sb_q.size() > 0) begin
      e      = sb_q.pop_front();
      o.fs   = o_frame_start;
      o.draw = o_draw_active;
      o.x    = o_active_x;
      o.y    = o_active_y;
      check($sformatf("pixel(%0d,%0d)", gx, gy), 32'(o), 32'(e));
    end
    if (gx == H_TOTAL - 1) begin
      gx = 0;
      gy = (gy == V_TOTAL - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  task automatic run_to(input int x, input int y);
    int k = 0;
    while (!(gx == x && gy == y) && k < FRAME) begin
      tick(1'b0);
      k++;
    end
  endtask

  task automatic wait_lock(input string tag, input int limit, output int cnt);
    cnt = 0;
    while (o_locked !== 1'b1 && cnt < limit) begin
      tick(1'b0);
      cnt++;
    end
    check(tag, 32'(o_locked), 32'd1);
  endtask

  task automatic clear_lost();
    lost_x      = -1;
    lost_err    = -1;
    lost_pulses = 0;
  endtask

  initial begin
    sif.h_sync = 1'b1;
    sif.v_sync = 1'b1;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({o_locked, o_lock_lost, o_frame_start, o_draw_active,
                                o_active_x, o_active_y, o_err_cnt}), 32'd0);

    // Generator starts at (0,0) on the first cycle out of reset.
    wait_lock("init_lock", 3 * FRAME, n);
    check("init_lock_cycles", n, 2 * FRAME);

    sb_on = 1'b1;
    repeat (2 * FRAME) tick(1'b0);
    sb_on = 1'b0;
    check("init_err_cnt", 32'(o_err_cnt), 32'd0);

    // h pulse one cycle too long on line 0.
    run_to(0, 0);
    clear_lost();
    mod_stretch = 1'b1;
    repeat (H_TOTAL) tick(1'b0);
    mod_stretch = 1'b0;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
    check("stretch_err_x", lost_x, HS_END);
    check("stretch_err_cnt", lost_err, exp_err + 1);
    exp_err++;
    wait_lock("stretch_relock", 4 * FRAME, n);
`else
    check("stretch_err_x", lost_x, -1);
    check("stretch_locked", 32'(o_locked), 32'd1);
`endif
    check("stretch_err_total", 32'(o_err_cnt), exp_err);

    // h fall one cycle late on line 0: misses at HS_START, then the misaligned hunt fails once more.
    run_to(0, 0);
    clear_lost();
    mod_delay = 1'b1;
    repeat (H_TOTAL) tick(1'b0);
    mod_delay = 1'b0;
    check("delay_err_x", lost_x, HS_START);
    check("delay_err_cnt", lost_err, exp_err + 1);
    check("delay_lost_pulses", lost_pulses, 1);
    check("delay_unlocked", 32'(o_locked), 32'd0);
    wait_lock("delay_relock", 4 * FRAME, n);
    exp_err += 2;
    check("delay_err_total", 32'(o_err_cnt), exp_err);

    // 300 lines with no h pulse, each followed by a good line, saturate the error count.
    run_to(0, 0);
    clear_lost();
    for (int k = 0; k < 300; k++) begin
      mod_skip = 1'b1;
      repeat (H_TOTAL) tick(1'b0);
      mod_skip = 1'b0;
      repeat (H_TOTAL) tick(1'b0);
    end
    check("skip_err_x", lost_x, HS_START);
    check("skip_err_first", lost_err, exp_err + 1);
    check("skip_lost_pulses", lost_pulses, 1);
    check("skip_err_sat", 32'(o_err_cnt), 32'd255);
    check("skip_unlocked", 32'(o_locked), 32'd0);
    wait_lock("skip_relock", 4 * FRAME, n);
    check("skip_err_hold", 32'(o_err_cnt), 32'd255);

    // One-cycle reset mid-frame at (5,3) while locked.
    run_to(5, 3);
    clear_lost();
    tick(1'b1);
    check("midrst_outputs", 32'({o_locked, o_lock_lost, o_frame_start, o_draw_active,
                                 o_active_x, o_active_y, o_err_cnt}), 32'd0);
    wait_lock("midrst_relock", 3 * FRAME, n);
    check("midrst_lock_cycles", n, 2 * FRAME - 1 - (3 * H_TOTAL + 5));
    check("midrst_err_cnt", 32'(o_err_cnt), 32'd0);
    check("midrst_no_lost", lost_pulses, 0);

    sb_on = 1'b1;
    repeat (FRAME) tick(1'b0);
    sb_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
